// File: rtl/ps2_key_event_if.sv
// Scan-code byte side (receiver FIFO) and key-event side (consumer) of ps2_key_event.
// master is the key-event stage; slave is the receiver FIFO / event consumer environment.
interface ps2_key_event_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_nextdata_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (
        input  kb_data, kb_ready, evt_ready,
        output kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
    );

    modport slave (
        output kb_data, kb_ready, evt_ready,
        input  kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
    );
endinterface

// File: rtl/ps2_key_event.sv
// Assembles PS/2 scan-code bytes (E0/F0 prefixes) into back-pressured key events.
// Optional macro PS2_REPEAT_FILTER_EN drops typematic repeats of the currently held key.
module ps2_key_event #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    ps2_key_event_if.master  bus,
    output logic [CNT_W-1:0] press_count,
    output logic             key_held
);

    typedef enum logic [2:0] {StIdle, StPop, StSettle, StDecode, StEmit} state_e;

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             ext_p_q, ext_p_d;
    logic             brk_p_q, brk_p_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             valid_q, valid_d;
    logic [7:0]       code_q, code_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [8:0]       held_q, held_d;
    logic             held_v_q, held_v_d;
    logic             emit;

`ifdef PS2_REPEAT_FILTER_EN
    // A make of the key already held is a typematic repeat.
    assign emit = !(held_v_q && !brk_p_q && ({ext_p_q, byte_q} == held_q));
`else
    assign emit = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        ext_p_d      = ext_p_q;
        brk_p_d      = brk_p_q;
        nextdata_n_d = nextdata_n_q;
        valid_d      = valid_q;
        code_d       = code_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        count_d      = count_q;
        held_d       = held_q;
        held_v_d     = held_v_q;
        case (state_q)
            StIdle: begin
                if (bus.kb_ready) begin
                    byte_d       = bus.kb_data;
                    nextdata_n_d = 1'b0;
                    state_d      = StPop;
                end
            end
            StPop: begin
                nextdata_n_d = 1'b1;
                state_d      = StSettle;
            end
            StSettle: state_d = StDecode;
            StDecode: begin
                state_d = StIdle;
                if (byte_q == 8'hE0) begin
                    ext_p_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_p_d = 1'b1;
                end else begin
                    code_d  = byte_q;
                    ext_d   = ext_p_q;
                    brk_d   = brk_p_q;
                    ext_p_d = 1'b0;
                    brk_p_d = 1'b0;
                    if (!brk_p_q) begin
                        held_v_d = 1'b1;
                        held_d   = {ext_p_q, byte_q};
                        if (emit) count_d = count_q + 1'b1;
                    end else if ({ext_p_q, byte_q} == held_q) begin
                        held_v_d = 1'b0;
                    end
                    if (emit) begin
                        valid_d = 1'b1;
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (bus.evt_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= StIdle;
            byte_q       <= 8'h00;
            ext_p_q      <= 1'b0;
            brk_p_q      <= 1'b0;
            nextdata_n_q <= 1'b1;
            valid_q      <= 1'b0;
            code_q       <= 8'h00;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            count_q      <= '0;
            held_q       <= 9'h000;
            held_v_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            ext_p_q      <= ext_p_d;
            brk_p_q      <= brk_p_d;
            nextdata_n_q <= nextdata_n_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            count_q      <= count_d;
            held_q       <= held_d;
            held_v_q     <= held_v_d;
        end
    end

    assign bus.kb_nextdata_n = nextdata_n_q;
    assign bus.evt_valid     = valid_q;
    assign bus.evt_code      = code_q;
    assign bus.evt_ext       = ext_q;
    assign bus.evt_break     = brk_q;
    assign press_count       = count_q;
    assign key_held          = held_v_q;

endmodule
